fb_triple_buffer_arbiter: RTL
=============================

Name: fb_triple_buffer_arbiter

Overview:
- Shares one single-port frame memory between the capture writer and the display reader.
- Triple-buffer bank scheduler: the writer fills a write bank, completed frames move to a back bank, and the display swaps to the newest frame only at its frame start.
- Display reads have strict priority; capture writes use valid/ready handshakes and fill idle cycles.
- Sits between the camera capture path, display_interface and the frame RAM.

Parameters:
- FRAME_PIXELS, 307200: pixels per bank (640x480).
- MEM_LAT, 1: frame RAM read latency in cycles (1..4).

Ports:
- i_clk  in  1  pixel clock; the only clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_rd_frame_start  in  1  one-cycle pulse from display timing at frame start.
- i_rd_req  in  1  display read request, single beat.
- i_rd_addr  in  19  pixel index within the frame.
- o_rd_valid  out  1  read data valid.
- o_rd_data  out  12  read pixel data.
- i_wr_frame_done  in  1  one-cycle pulse after the last pixel of a frame is accepted.
- i_wr_valid  in  1  capture write valid.
- i_wr_addr  in  19  pixel index.
- i_wr_data  in  12  pixel data.
- o_wr_ready  out  1  write accepted this cycle when high together with i_wr_valid.
- o_mem_en  out  1  memory access strobe.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  21  {bank[1:0], pixel[18:0]}.
- o_mem_wdata  out  12  memory write data.
- i_mem_rdata  in  12  memory read data, valid MEM_LAT cycles after o_mem_en with o_mem_we=0.
- o_front_valid  out  1  front bank holds a complete frame.
- o_front_bank  out  2  bank currently displayed.
- o_drop_cnt  out  16  frames overwritten before display.
- o_repeat_cnt  out  16  frames displayed again.

Behaviour:
- Reset values:
  - front=0, back=1, write=2, fresh=0, o_front_valid=0.
  - All o_mem_* = 0; o_rd_valid=0, o_rd_data=0.
  - Counters = 0; read pipeline cleared.
- Arbitration:
  - o_wr_ready = !i_rd_req (combinational).
  - A read is accepted every cycle i_rd_req=1.
  - A write is accepted when i_wr_valid && !i_rd_req.
  - At most one access per cycle.
- Memory port:
  - Registered. An access accepted in cycle t appears on o_mem_* in t+1.
  - An idle cycle drives o_mem_en=0 and o_mem_we=0.
- Address mapping:
  - Reads use front; writes use write.
  - Bank values are sampled at acceptance, so an access in a swap cycle uses the pre-swap bank.
- Read latency:
  - Accepted in t -> o_rd_valid=1 for one cycle in t+2+MEM_LAT, with o_rd_data registered from i_mem_rdata.
  - Back-to-back reads give back-to-back valids.
- Out-of-range (addr >= FRAME_PIXELS):
  - Write: accepted but no memory access.
  - Read: no memory access; o_rd_valid still fires at the same latency with o_rd_data=12'h000.
- Bank FSM, evaluated per cycle:
  - wr_done only: swap write<->back; if fresh was 1, drop++; fresh<=1.
  - rd_start only, fresh=1: swap front<->back; fresh<=0; o_front_valid<=1.
  - rd_start only, fresh=0: no change; if o_front_valid, repeat++.
  - Both in the same cycle: front<=old write, write<=old front, back unchanged, fresh<=0, o_front_valid<=1; if fresh was 1, drop++.
- Invariant: front, back and write are always distinct values in {0,1,2}.
- Counters saturate at 16'hFFFF.
- Reset mid-operation: the read pipeline is flushed with no o_rd_valid pulses, and the bank state returns to reset values.

Optional Feature:
- Macro: FB_STATS_EN.
- Defined: drop and repeat counters are implemented as above.
- Undefined: o_drop_cnt and o_repeat_cnt are tied to 0 and no counter flops are inferred.

Decomposition:
- Package fb_pkg holds:
  - FB_PIX_W=19, FB_DATA_W=12, FB_BANK_W=2, FB_FRAME_PIXELS=307200.
  - Bank reset constants FB_FRONT_RST=0, FB_BACK_RST=1, FB_WRITE_RST=2.
- One sub-module, fb_bank_sched:
  - Contains the bank rotation FSM plus the fresh and front_valid flags, and the stats counters under FB_STATS_EN.
  - Outputs front and write bank indices to the arbiter datapath.

Test Plan:
- Reset, then one write (addr 5, data 12'hABC) with i_rd_req=0 -> o_wr_ready=1; next cycle o_mem_en=1, o_mem_we=1, o_mem_addr={2'd2,19'd5}, o_mem_wdata=12'hABC.
- i_rd_req and i_wr_valid both high for 3 cycles -> o_wr_ready=0 throughout; 3 reads issued to bank 0; o_rd_valid pulses in cycles t+3..t+5 (MEM_LAT=1); the write is issued in the first cycle i_rd_req=0.
- wr_done, then rd_start -> o_front_bank=2, o_front_valid=1, write bank=1 (next write addr {2'd1,...}); a second rd_start with no new frame -> repeat_cnt=1.
- Two wr_done pulses with no rd_start -> drop_cnt=1 (FB_STATS_EN defined) and fresh=1; with the macro undefined -> o_drop_cnt=0.
- wr_done and rd_start in the same cycle from reset -> front=2, write=0, back=1, fresh=0.
- Read at addr 307200 -> no o_mem_en; o_rd_valid at +3 with data 0; assert i_rstn=0 with reads in flight -> o_rd_valid stays 0 and banks return to 0/1/2.

Source files
------------

// File: rtl/fb_triple_buffer_arbiter_pkg.sv
// Shared widths, bank reset constants and scheduler state type for the
// triple-buffer frame memory arbiter.
package fb_pkg;

  localparam int unsigned FB_PIX_W        = 19;
  localparam int unsigned FB_DATA_W       = 12;
  localparam int unsigned FB_BANK_W       = 2;
  localparam int unsigned FB_CNT_W        = 16;
  localparam int unsigned FB_FRAME_PIXELS = 307200;

  typedef logic [FB_BANK_W-1:0]          bank_t;
  typedef logic [FB_PIX_W-1:0]           pix_t;
  typedef logic [FB_DATA_W-1:0]          data_t;
  typedef logic [FB_BANK_W+FB_PIX_W-1:0] mem_addr_t;
  typedef logic [FB_CNT_W-1:0]           cnt_t;

  localparam bank_t FB_FRONT_RST = 2'd0;
  localparam bank_t FB_BACK_RST  = 2'd1;
  localparam bank_t FB_WRITE_RST = 2'd2;

  typedef struct packed {
    bank_t front;
    bank_t back;
    bank_t write;
    logic  fresh;
    logic  front_valid;
  } sched_t;

  localparam sched_t FB_SCHED_RST = '{
    front:       FB_FRONT_RST,
    back:        FB_BACK_RST,
    write:       FB_WRITE_RST,
    fresh:       1'b0,
    front_valid: 1'b0
  };

endpackage

// File: rtl/fb_triple_buffer_arbiter_if.sv
// Display-read, capture-write, frame-RAM and status bundle of the arbiter;
// slave is the arbiter's view, master the surrounding system's view.
interface fb_triple_buffer_arbiter_if;
  import fb_pkg::*;

  logic      i_rd_frame_start;
  logic      i_rd_req;
  pix_t      i_rd_addr;
  logic      o_rd_valid;
  data_t     o_rd_data;
  logic      i_wr_frame_done;
  logic      i_wr_valid;
  pix_t      i_wr_addr;
  data_t     i_wr_data;
  logic      o_wr_ready;
  logic      o_mem_en;
  logic      o_mem_we;
  mem_addr_t o_mem_addr;
  data_t     o_mem_wdata;
  data_t     i_mem_rdata;
  logic      o_front_valid;
  bank_t     o_front_bank;
  cnt_t      o_drop_cnt;
  cnt_t      o_repeat_cnt;

  modport slave (
    input  i_rd_frame_start, i_rd_req, i_rd_addr,
    input  i_wr_frame_done, i_wr_valid, i_wr_addr, i_wr_data,
    input  i_mem_rdata,
    output o_rd_valid, o_rd_data, o_wr_ready,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_front_valid, o_front_bank, o_drop_cnt, o_repeat_cnt
  );

  modport master (
    output i_rd_frame_start, i_rd_req, i_rd_addr,
    output i_wr_frame_done, i_wr_valid, i_wr_addr, i_wr_data,
    output i_mem_rdata,
    input  o_rd_valid, o_rd_data, o_wr_ready,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_front_valid, o_front_bank, o_drop_cnt, o_repeat_cnt
  );

endinterface

// File: rtl/fb_triple_buffer_arbiter_bank_sched.sv
// Triple-buffer bank rotation with fresh/front_valid tracking.
// Drop/repeat statistics exist only when FB_STATS_EN is defined.
module fb_bank_sched
  import fb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_done,
  input  logic  rd_start,
  output bank_t front,
  output bank_t write_bank,
  output logic  front_valid,
  output cnt_t  drop_cnt,
  output cnt_t  repeat_cnt
);

  sched_t st, nxt;
  logic   drop_inc, repeat_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= FB_SCHED_RST;
    else        st <= nxt;
  end

  always_comb begin
    nxt        = st;
    drop_inc   = 1'b0;
    repeat_inc = 1'b0;
    unique case ({wr_done, rd_start})
      2'b10: begin
        nxt.write = st.back;
        nxt.back  = st.write;
        nxt.fresh = 1'b1;
        drop_inc  = st.fresh;
      end
      2'b01: begin
        if (st.fresh) begin
          nxt.front       = st.back;
          nxt.back        = st.front;
          nxt.fresh       = 1'b0;
          nxt.front_valid = 1'b1;
        end else begin
          repeat_inc = st.front_valid;
        end
      end
      // Frame just completed goes straight to display; the stale back frame is dropped.
      2'b11: begin
        nxt.front       = st.write;
        nxt.write       = st.front;
        nxt.fresh       = 1'b0;
        nxt.front_valid = 1'b1;
        drop_inc        = st.fresh;
      end
      default: ;
    endcase
  end

  assign front       = st.front;
  assign write_bank  = st.write;
  assign front_valid = st.front_valid;

`ifdef FB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      repeat_cnt <= '0;
    end else begin
      if (drop_inc && (drop_cnt != '1))     drop_cnt   <= drop_cnt + 1'b1;
      if (repeat_inc && (repeat_cnt != '1)) repeat_cnt <= repeat_cnt + 1'b1;
    end
  end
`else
  logic unused_inc;
  assign unused_inc = drop_inc | repeat_inc;
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
`endif

endmodule

// File: rtl/fb_triple_buffer_arbiter.sv
// Single-port frame RAM arbiter: display reads win, capture writes fill idle
// cycles; bank selection from fb_bank_sched. Optional stats via FB_STATS_EN.
module fb_triple_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int unsigned MEM_LAT      = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  fb_triple_buffer_arbiter_if.slave   bus
);

  localparam pix_t PIX_LIMIT = pix_t'(FRAME_PIXELS);

  bank_t front, write_bank;
  logic  rd_in_range, wr_in_range;

  // Tracks accepted reads (and whether each was out of range) until RAM data returns.
  logic [MEM_LAT:0] rd_pipe, oor_pipe;

  fb_bank_sched u_sched (
    .clk         (i_clk),
    .rst_n       (i_rstn),
    .wr_done     (bus.i_wr_frame_done),
    .rd_start    (bus.i_rd_frame_start),
    .front       (front),
    .write_bank  (write_bank),
    .front_valid (bus.o_front_valid),
    .drop_cnt    (bus.o_drop_cnt),
    .repeat_cnt  (bus.o_repeat_cnt)
  );

  assign bus.o_front_bank = front;
  assign bus.o_wr_ready   = !bus.i_rd_req;
  assign rd_in_range      = bus.i_rd_addr < PIX_LIMIT;
  assign wr_in_range      = bus.i_wr_addr < PIX_LIMIT;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bus.o_mem_en    <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      rd_pipe         <= '0;
      oor_pipe        <= '0;
      bus.o_rd_valid  <= 1'b0;
      bus.o_rd_data   <= '0;
    end else begin
      if (bus.i_rd_req) begin
        bus.o_mem_en    <= rd_in_range;
        bus.o_mem_we    <= 1'b0;
        bus.o_mem_addr  <= {front, bus.i_rd_addr};
        bus.o_mem_wdata <= '0;
      end else if (bus.i_wr_valid) begin
        bus.o_mem_en    <= wr_in_range;
        bus.o_mem_we    <= wr_in_range;
        bus.o_mem_addr  <= {write_bank, bus.i_wr_addr};
        bus.o_mem_wdata <= bus.i_wr_data;
      end else begin
        bus.o_mem_en <= 1'b0;
        bus.o_mem_we <= 1'b0;
      end

      rd_pipe  <= {rd_pipe[MEM_LAT-1:0], bus.i_rd_req};
      oor_pipe <= {oor_pipe[MEM_LAT-1:0], bus.i_rd_req && !rd_in_range};

      bus.o_rd_valid <= rd_pipe[MEM_LAT];
      if (rd_pipe[MEM_LAT])
        bus.o_rd_data <= oor_pipe[MEM_LAT] ? '0 : bus.i_mem_rdata;
    end
  end

endmodule
